// File: rtl/mpq_pkg.sv
// mpq_pkg: opcode and state encodings shared by the mpq_param heap engine.
package mpq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_BUILD    = 3'b000,
        OP_EXTRACT  = 3'b001,
        OP_INCREASE = 3'b010,
        OP_INSERT   = 3'b011,
        OP_WRITE    = 3'b100
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAPIFY,
        S_SIFTUP,
        S_BUILD_NEXT,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/mpq_pick3.sv
// mpq_pick3: best-of-(node, left, right) selector for one heapify step.
// Order follows MPQ_MIN_HEAP_EN; ties keep the parent, then the left child.
module mpq_pick3
    import mpq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] cur_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              left_ok_i,
    input  logic              right_ok_i,
    output logic [1:0]        sel_o
);

    function automatic logic above(input logic [DATA_W-1:0] x,
                                   input logic [DATA_W-1:0] y);
`ifdef MPQ_MIN_HEAP_EN
        return x < y;
`else
        return x > y;
`endif
    endfunction

    logic              lwin;
    logic [DATA_W-1:0] lbest;

    always_comb begin
        lwin  = left_ok_i && above(left_i, cur_i);
        lbest = lwin ? left_i : cur_i;
        sel_o = lwin ? 2'd1 : 2'd0;
        if (right_ok_i && above(right_i, lbest)) begin
            sel_o = 2'd2;
        end
    end

endmodule

// File: rtl/mpq_param.sv
// mpq_param: parametrised binary-heap priority queue with RAM dump port.
// Define MPQ_MIN_HEAP_EN for a min-heap (INCREASE acts as decrease-key).
module mpq_param
    import mpq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              cmd_valid,
    input  logic [OP_W-1:0]   cmd,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [IDX_W:0]    count,
    output logic              err,
    output logic              RAM_valid,
    output logic [IDX_W-1:0]  RAM_A,
    output logic [DATA_W-1:0] RAM_D,
    output logic              done
);

    localparam int             CW   = IDX_W + 2;
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] CNT1 = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] CNT2 = (IDX_W+1)'(2);
    localparam logic [IDX_W-1:0] IDX1 = IDX_W'(1);

    function automatic logic above(input logic [DATA_W-1:0] x,
                                   input logic [DATA_W-1:0] y);
`ifdef MPQ_MIN_HEAP_EN
        return x < y;
`else
        return x > y;
`endif
    endfunction

    logic [DATA_W-1:0] a_q [DEPTH];
    state_e            state_q;
    logic [IDX_W:0]    n_q;
    logic [IDX_W:0]    k_q;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  bi_q;
    logic              build_q;
    logic              busy_q;
    logic              err_q;
    logic              done_q;
    logic              ram_v_q;
    logic [IDX_W-1:0]  ram_a_q;
    logic [DATA_W-1:0] ram_d_q;

    logic [CW-1:0]     l_w;
    logic [CW-1:0]     r_w;
    logic              l_ok;
    logic              r_ok;
    logic [1:0]        sel_w;
    logic [IDX_W-1:0]  best_w;
    logic [IDX_W-1:0]  par_w;
    logic [IDX_W-1:0]  last_w;
    logic [IDX_W-1:0]  half_w;
    logic [DATA_W-1:0] key_i;
    logic [DATA_W-1:0] key_l;
    logic [DATA_W-1:0] key_r;
    logic [DATA_W-1:0] key_b;
    logic [DATA_W-1:0] key_p;
    logic              up_w;
    logic              inc_ok;

    assign l_w    = {1'b0, i_q, 1'b1};
    assign r_w    = l_w + CW'(1);
    assign l_ok   = l_w < CW'(n_q);
    assign r_ok   = r_w < CW'(n_q);
    assign key_i  = a_q[i_q];
    assign key_l  = a_q[l_w[IDX_W-1:0]];
    assign key_r  = a_q[r_w[IDX_W-1:0]];
    assign best_w = sel_w[1] ? r_w[IDX_W-1:0] : l_w[IDX_W-1:0];
    assign key_b  = sel_w[1] ? key_r : key_l;
    assign par_w  = (i_q - IDX1) >> 1;
    assign key_p  = a_q[par_w];
    assign up_w   = (i_q != '0) && above(key_i, key_p);
    assign last_w = IDX_W'(n_q - CNT1);
    assign half_w = IDX_W'((n_q >> 1) - CNT1);
    assign inc_ok = ({1'b0, index} < n_q) && above(value, a_q[index]);

    mpq_pick3 #(
        .DATA_W(DATA_W)
    ) u_pick (
        .cur_i     (key_i),
        .left_i    (key_l),
        .right_i   (key_r),
        .left_ok_i (l_ok),
        .right_ok_i(r_ok),
        .sel_o     (sel_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            i_q     <= '0;
            bi_q    <= '0;
            build_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ram_v_q <= 1'b0;
            ram_a_q <= '0;
            ram_d_q <= '0;
        end else begin
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ram_v_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            OP_BUILD: begin
                                if (n_q >= CNT2) begin
                                    i_q     <= half_w;
                                    bi_q    <= half_w;
                                    build_q <= 1'b1;
                                    busy_q  <= 1'b1;
                                    state_q <= S_HEAPIFY;
                                end
                            end
                            OP_EXTRACT: begin
                                if (n_q == '0) begin
                                    err_q <= 1'b1;
                                end else begin
                                    a_q[0]  <= a_q[last_w];
                                    n_q     <= n_q - CNT1;
                                    i_q     <= '0;
                                    build_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                    state_q <= S_HEAPIFY;
                                end
                            end
                            OP_INCREASE: begin
                                if (!inc_ok) begin
                                    err_q <= 1'b1;
                                end else begin
                                    a_q[index] <= value;
                                    i_q        <= index;
                                    busy_q     <= 1'b1;
                                    state_q    <= S_SIFTUP;
                                end
                            end
                            OP_INSERT: begin
                                if (n_q == FULL) begin
                                    err_q <= 1'b1;
                                end else begin
                                    a_q[IDX_W'(n_q)] <= value;
                                    i_q     <= IDX_W'(n_q);
                                    n_q     <= n_q + CNT1;
                                    busy_q  <= 1'b1;
                                    state_q <= S_SIFTUP;
                                end
                            end
                            OP_WRITE: begin
                                busy_q <= 1'b1;
                                if (n_q == '0) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    ram_v_q <= 1'b1;
                                    ram_a_q <= '0;
                                    ram_d_q <= a_q[0];
                                    k_q     <= CNT1;
                                    state_q <= S_WRITE;
                                end
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end else if (data_valid) begin
                        if (n_q == FULL) begin
                            err_q <= 1'b1;
                        end else begin
                            a_q[IDX_W'(n_q)] <= data;
                            n_q <= n_q + CNT1;
                        end
                    end
                end
                S_HEAPIFY: begin
                    if (sel_w != 2'd0) begin
                        a_q[i_q]    <= key_b;
                        a_q[best_w] <= key_i;
                        i_q         <= best_w;
                    end else if (build_q && bi_q != '0) begin
                        state_q <= S_BUILD_NEXT;
                    end else begin
                        build_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_BUILD_NEXT: begin
                    bi_q    <= bi_q - IDX1;
                    i_q     <= bi_q - IDX1;
                    state_q <= S_HEAPIFY;
                end
                S_SIFTUP: begin
                    if (up_w) begin
                        a_q[i_q]   <= key_p;
                        a_q[par_w] <= key_i;
                        i_q        <= par_w;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (k_q < n_q) begin
                        ram_v_q <= 1'b1;
                        ram_a_q <= k_q[IDX_W-1:0];
                        ram_d_q <= a_q[k_q[IDX_W-1:0]];
                        k_q     <= k_q + CNT1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign count     = n_q;
    assign err       = err_q;
    assign done      = done_q;
    assign RAM_valid = ram_v_q;
    assign RAM_A     = ram_a_q;
    assign RAM_D     = ram_d_q;

endmodule
